uart_rx_word_packer: RTL and testbench

//   Sits directly downstream of the UART receiver's AXI4-Stream byte output.

---
 rtl/uart_rx_word_packer.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_word_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer
// Purpose  : Packs UART receiver bytes big-endian into 32-bit AXI4-Stream
//            words, marks the last word of each message block with tlast,
//            flushes a partial word after an idle timeout and discards the
//            word/block in progress on a receive frame error.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_packer #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int TIMEOUT         = 1024,
    parameter int ERR_CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     rx_frame_error,
    output logic [31:0]              m_axis_tdata,
    output logic [3:0]               m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int C_WC_W  = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int C_TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [C_WC_W-1:0]        C_LAST_WORD = C_WC_W'(WORDS_PER_BLOCK - 1);
    localparam logic [C_WC_W-1:0]        C_WC_ONE    = C_WC_W'(1);
    localparam logic [C_TMR_W-1:0]       C_TMR_MAX   = C_TMR_W'(TIMEOUT);
    localparam logic [C_TMR_W-1:0]       C_TMR_ONE   = C_TMR_W'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_ONE   = ERR_CNT_WIDTH'(1);

    // Assembly register holds word lanes [31:8]; lane [7:0] is never stored
    // because the fourth byte goes straight into the output register.
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [23:0]              asm_q,      asm_d;
    logic [C_WC_W-1:0]        word_cnt_q, word_cnt_d;
    logic [C_TMR_W-1:0]       timer_q,    timer_d;
    logic [31:0]              tdata_q,    tdata_d;
    logic [3:0]               tkeep_q,    tkeep_d;
    logic                     tlast_q,    tlast_d;
    logic                     tvalid_q,   tvalid_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q,  err_cnt_d;

    logic        w_accept;
    logic        w_flush;
    logic [3:0]  w_flush_keep;
    logic [31:0] w_flush_mask;

    // Ready depends on registered state only: stall the 4th byte while the
    // output register is still occupied.
    assign s_axis_tready = !((byte_idx_q == 2'd3) && tvalid_q);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign err_count     = err_cnt_q;

    // Flush qualification and msb-first keep mask for a partial word.
    always_comb begin
        w_accept     = s_axis_tvalid && s_axis_tready;
        w_flush_keep = 4'h0;
        case (byte_idx_q)
            2'd1:    w_flush_keep = 4'h8;
            2'd2:    w_flush_keep = 4'hC;
            2'd3:    w_flush_keep = 4'hE;
            default: w_flush_keep = 4'h0;
        endcase
        w_flush_mask = {{8{w_flush_keep[3]}}, {8{w_flush_keep[2]}},
                        {8{w_flush_keep[1]}}, {8{w_flush_keep[0]}}};
        w_flush      = (TIMEOUT > 0) && (byte_idx_q != 2'd0) && !w_accept &&
                       !rx_frame_error && (timer_q == C_TMR_MAX) && !tvalid_q;
    end

    // Next-state: byte assembly, word load, timeout flush, frame-error discard.
    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        err_cnt_d  = err_cnt_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (rx_frame_error) begin
            // Abandon the partial word, any byte arriving with the error, and
            // the block in progress; an already loaded output word survives.
            byte_idx_d = 2'd0;
            timer_d    = '0;
            word_cnt_d = '0;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + C_ERR_ONE;
            end
        end else if (w_accept) begin
            timer_d = '0;
            if (byte_idx_q == 2'd3) begin
                tdata_d    = {asm_q, s_axis_tdata};
                tkeep_d    = 4'hF;
                tlast_d    = (word_cnt_q == C_LAST_WORD);
                tvalid_d   = 1'b1;
                word_cnt_d = (word_cnt_q == C_LAST_WORD) ? '0 : word_cnt_q + C_WC_ONE;
                byte_idx_d = 2'd0;
            end else begin
                case (byte_idx_q)
                    2'd0:    asm_d[23:16] = s_axis_tdata;
                    2'd1:    asm_d[15:8]  = s_axis_tdata;
                    default: asm_d[7:0]   = s_axis_tdata;
                endcase
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end else if (w_flush) begin
            // A flushed partial word also closes the block.
            tdata_d    = {asm_q, 8'h00} & w_flush_mask;
            tkeep_d    = w_flush_keep;
            tlast_d    = 1'b1;
            tvalid_d   = 1'b1;
            byte_idx_d = 2'd0;
            word_cnt_d = '0;
            timer_d    = '0;
        end else if ((TIMEOUT > 0) && (byte_idx_q != 2'd0) && (timer_q != C_TMR_MAX)) begin
            // Saturates at the limit so a stalled output still flushes later.
            timer_d = timer_q + C_TMR_ONE;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            word_cnt_q <= '0;
            timer_q    <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_word_packer
// Purpose  : Self-checking bench for uart_rx_word_packer. Directed scenarios
//            plus a randomized byte stream compared against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_packer;

    localparam int WPB = 16;
    localparam int TMO = 16;
    localparam int ECW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic            rx_err;
    logic [31:0]     m_tdata;
    logic [3:0]      m_tkeep;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [ECW-1:0]  err_cnt;

    logic            m_tready_dir;
    logic            m_tready_rnd = 1'b1;
    logic            rnd_en;

    int n_cmp = 0;
    int n_err = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic [7:0]  sent_q[$];

    assign m_tready = rnd_en ? m_tready_rnd : m_tready_dir;

    always #5 clk = ~clk;

    uart_rx_word_packer #(
        .WORDS_PER_BLOCK (WPB),
        .TIMEOUT         (TMO),
        .ERR_CNT_WIDTH   (ECW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .rx_frame_error (rx_err),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .err_count      (err_cnt)
    );

    // Random downstream back-pressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1 m_tready_rnd = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: records every word handshake seen before the next edge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) got_q.push_back({m_tdata, m_tkeep, m_tlast});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tvalid = 1'b0; rx_err = 1'b0; s_tdata = 8'h00;
        idle(2);
        rst = 1'b0;
        got_q.delete(); exp_q.delete(); sent_q.delete();
    endtask

    // Present one byte and hold it until the packer takes it.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        s_tdata = b; s_tvalid = 1'b1;
        sent_q.push_back(b);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    // Reference: consecutive 4-byte groups, first byte in the top lane,
    // tlast on every WPB-th word counted from the start of the stream.
    task automatic model_pack();
        for (int w = 0; 4 * w + 3 < sent_q.size(); w++) begin
            exp_q.push_back({sent_q[4*w], sent_q[4*w+1], sent_q[4*w+2], sent_q[4*w+3],
                             4'hF, ((w % WPB) == WPB - 1)});
        end
    endtask

    task automatic compare_q(input string tag);
        for (int i = 0; i < 800 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        idle(8);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  stable;
        bit  quiet;
        rnd_en = 1'b0; m_tready_dir = 1'b1;
        rst = 1'b1; s_tvalid = 1'b0; rx_err = 1'b0; s_tdata = 8'h00;
        idle(3);

        // Reset values
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m_tdata),  64'd0);
        chk("rst_m_tkeep",  64'(m_tkeep),  64'd0);
        chk("rst_m_tlast",  64'(m_tlast),  64'd0);
        chk("rst_err_cnt",  64'(err_cnt),  64'd0);
        do_reset();

        // T1: single word, one-cycle latency after the 4th byte
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("t1_no_early_valid", 64'(m_tvalid), 64'd0);
        send_byte(8'h04);
        chk("t1_valid_latency", 64'(m_tvalid), 64'd1);
        chk("t1_word_now", 64'({m_tdata, m_tkeep, m_tlast}), 64'({32'h01020304, 4'hF, 1'b0}));
        exp_q.push_back({32'h01020304, 4'hF, 1'b0});
        compare_q("t1");

        // T2: full block plus first word of the next block
        do_reset();
        for (int i = 0; i < 68; i++) send_byte(8'(i));
        model_pack();
        compare_q("t2");

        // T3: back-pressure holds word0 and stalls the 4th byte of word1
        do_reset();
        m_tready_dir = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        chk("t3_word0_valid", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hA0A1A2A3}));
        for (int i = 4; i < 7; i++) send_byte(8'hA0 + 8'(i));
        s_tdata = 8'hA7; s_tvalid = 1'b1;
        stable = 1;
        repeat (24) begin
            @(negedge clk);
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'hA0A1A2A3) stable = 0;
        end
        chk("t3_stall_hold", 64'(stable), 64'd1);
        @(posedge clk); #1;
        m_tready_dir = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_tready) break;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        exp_q.push_back({32'hA0A1A2A3, 4'hF, 1'b0});
        exp_q.push_back({32'hA4A5A6A7, 4'hF, 1'b0});
        compare_q("t3");

        // T4: idle timeout flushes a 2-byte partial word, then block restarts
        do_reset();
        send_byte(8'hAA); send_byte(8'hBB);
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (m_tvalid) seen = 1;
        end
        @(posedge clk); #1;
        chk("t4_flush_seen", 64'(seen), 64'd1);
        chk("t4_flush_after_16_idle", 64'((n >= 17) && (n <= 18)), 64'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        exp_q.push_back({32'hAABB0000, 4'hC, 1'b1});
        exp_q.push_back({32'h01020304, 4'hF, 1'b0});
        compare_q("t4");

        // T5: frame error discards partial word and the byte arriving with it
        do_reset();
        send_byte(8'h11); send_byte(8'h22);
        s_tdata = 8'h33; s_tvalid = 1'b1; rx_err = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0; rx_err = 1'b0;
        idle(30);
        chk("t5_no_word", 64'(got_q.size()), 64'd0);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        exp_q.push_back({32'h44556677, 4'hF, 1'b0});
        compare_q("t5");
        chk("t5_err_count", 64'(err_cnt), 64'd1);

        // T6: error counter saturation, then reset mid-word
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rx_err = 1'b1; idle(1);
            rx_err = 1'b0; idle(1);
            if (i == 99) chk("t6_err_100", 64'(err_cnt), 64'd100);
        end
        chk("t6_err_sat", 64'(err_cnt), 64'd255);
        m_tready_dir = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i));
        chk("t6_pre_rst_valid", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_outputs", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast, err_cnt, s_tready}),
            64'({1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b1}));
        rst = 1'b0;
        m_tready_dir = 1'b1;
        quiet = 1;
        repeat (40) begin
            @(negedge clk);
            if (m_tvalid !== 1'b0) quiet = 0;
        end
        @(posedge clk); #1;
        chk("t6_no_flush_after_rst", 64'(quiet), 64'd1);

        // Randomized stream with random gaps and random back-pressure
        do_reset();
        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send_byte(8'($urandom));
            idle($urandom_range(0, 3));
        end
        model_pack();
        compare_q("rnd");
        rnd_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
